// File: rtl/arbitro_contador.sv
// Round-robin arbiter for 4 requesters sharing one push path, with a 6-bit push counter per channel.
// Grant/push and read responses are registered (1 cycle); no backpressure, requests are level-sensitive.
module arbitro_contador #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 6,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             push,
  output logic [IDX_W-1:0] push_id,
  output logic             idle,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_cuenta
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACTIVE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] win, scan;
  logic             win_vld;
  logic [CNT_W-1:0] cnt     [N_REQ];
  logic [CNT_W-1:0] cnt_nxt [N_REQ];
  logic [N_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0] push_id_nxt;
  logic             rd_valid_nxt;
  logic [CNT_W-1:0] rd_cuenta_nxt;

  // Scan from the farthest offset down so the channel closest to ptr wins last.
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    scan    = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan = ptr + IDX_W'(k);
      if (req[scan]) begin
        win     = scan;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    grant_nxt     = '0;
    push_id_nxt   = push_id;
    cnt_nxt       = cnt;
    rd_valid_nxt  = 1'b0;
    rd_cuenta_nxt = rd_cuenta;
    if (init) begin
      state_nxt = ST_INIT;
      for (int i = 0; i < N_REQ; i++) cnt_nxt[i] = '0;
    end else begin
      // Read samples the pre-edge count, so a same-edge increment is not seen.
      if (rd_req && state != ST_INIT) begin
        rd_valid_nxt  = 1'b1;
        rd_cuenta_nxt = cnt[rd_idx];
      end
      case (state)
        ST_INIT: state_nxt = ST_IDLE;
        ST_IDLE, ST_ACTIVE: begin
          if (win_vld) begin
            state_nxt    = ST_ACTIVE;
            grant_nxt    = N_REQ'(1) << win;
            push_id_nxt  = win;
            cnt_nxt[win] = cnt[win] + 1'b1;
            ptr_nxt      = win + 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= ST_INIT;
      ptr       <= '0;
      grant     <= '0;
      push      <= 1'b0;
      push_id   <= '0;
      rd_valid  <= 1'b0;
      rd_cuenta <= '0;
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant     <= grant_nxt;
      push      <= |grant_nxt;
      push_id   <= push_id_nxt;
      rd_valid  <= rd_valid_nxt;
      rd_cuenta <= rd_cuenta_nxt;
      for (int i = 0; i < N_REQ; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign idle = (state == ST_IDLE);

endmodule

// File: tb/tb_arbitro_contador.sv
// Bench for arbitro_contador: a reference model queues expected outputs per edge, popped after the edge.
module tb_arbitro_contador;

  logic       clk;
  logic       reset_L;
  logic       init;
  logic [3:0] req;
  logic [3:0] grant;
  logic       push;
  logic [1:0] push_id;
  logic       idle;
  logic       rd_req;
  logic [1:0] rd_idx;
  logic       rd_valid;
  logic [5:0] rd_cuenta;

  arbitro_contador #(.N_REQ(4), .CNT_W(6), .IDX_W(2)) dut (
    .clk(clk), .reset_L(reset_L), .init(init), .req(req),
    .grant(grant), .push(push), .push_id(push_id), .idle(idle),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_cuenta(rd_cuenta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] pid;
    logic       idle;
    logic       rd_vld;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] rd_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  // Reference model state: 0 INIT, 1 IDLE, 2 ACTIVE.
  int         m_state;
  logic [1:0] m_ptr;
  logic [1:0] m_pid;
  logic [5:0] m_cnt[4];
  logic [5:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ptr   = 2'd0;
    m_pid   = 2'd0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 6'd0;
    last_rd = 6'd0;
    exp_q.delete();
    rd_q.delete();
  endtask

  task automatic model_edge();
    exp_t e;
    int   w;
    e.rd_vld = 1'b0;
    e.grant  = 4'b0000;
    w        = -1;
    if (init) begin
      m_state = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 6'd0;
    end else begin
      if (rd_req && m_state != 0) begin
        e.rd_vld = 1'b1;
        rd_q.push_back(m_cnt[rd_idx]);
      end
      if (m_state == 0) begin
        m_state = 1;
      end else begin
        for (int k = 0; k < 4; k++)
          if (w < 0 && req[(int'(m_ptr) + k) % 4]) w = (int'(m_ptr) + k) % 4;
        if (w >= 0) begin
          e.grant  = 4'b0001 << w;
          m_pid    = 2'(w);
          m_cnt[w] = m_cnt[w] + 6'd1;
          m_ptr    = 2'(w + 1);
          m_state  = 2;
        end else begin
          m_state = 1;
        end
      end
    end
    e.pid  = m_pid;
    e.idle = (m_state == 1);
    exp_q.push_back(e);
  endtask

  // One clock edge: queue the expectation, then compare just after the edge.
  task automatic cyc();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("grant", grant, e.grant);
    chk("push", push, |e.grant);
    if (e.grant != 4'b0000) chk("push_id", push_id, e.pid);
    chk("idle", idle, e.idle);
    chk("rd_valid", rd_valid, e.rd_vld);
    if (e.rd_vld) last_rd = rd_q.pop_front();
    chk("rd_cuenta", rd_cuenta, last_rd);
  endtask

  task automatic rd_chk(input logic [1:0] idx, input logic [5:0] expv);
    rd_req = 1'b1;
    rd_idx = idx;
    cyc();
    chk("rd_const", rd_cuenta, expv);
    rd_req = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_push"}, push, 0);
    chk({tag, "_push_id"}, push_id, 0);
    chk({tag, "_idle"}, idle, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_cuenta"}, rd_cuenta, 0);
  endtask

  task automatic apply_reset();
    reset_L = 1'b0;
    init    = 1'b0;
    req     = 4'b0000;
    rd_req  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk_zero("rst");
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b0;
    init    = 1'b0;
    req     = 4'b0000;
    rd_req  = 1'b0;
    rd_idx  = 2'd0;

    // Basic init: zeros in reset, idle one edge after release.
    apply_reset();
    cyc();
    chk("init_idle", idle, 1);

    // Single requester.
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("single_grant", grant, 4'b0001);
    end
    req = 4'b0000;
    cyc();
    chk("single_back_idle", idle, 1);
    rd_chk(2'd0, 6'd5);

    // Round-robin over all four from ptr=0.
    apply_reset();
    cyc();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("rr_order", grant, 4'b0001 << (i % 4));
    end
    req = 4'b0000;
    for (int i = 0; i < 4; i++) rd_chk(2'(i), 6'd2);

    // Sparse requesters alternate.
    apply_reset();
    cyc();
    req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_sparse", grant, (i % 2 == 0) ? 4'b0010 : 4'b1000);
    end
    req = 4'b0000;
    cyc();

    // Counter wrap with a read on the wrapping edge.
    init = 1'b1;
    cyc();
    init = 1'b0;
    cyc();
    req = 4'b0100;
    for (int i = 0; i < 63; i++) cyc();
    rd_chk(2'd2, 6'd63);
    req = 4'b0000;
    rd_chk(2'd2, 6'd0);

    // Soft init mid-burst, read on the init edge is dropped.
    apply_reset();
    cyc();
    req = 4'b1111;
    for (int i = 0; i < 3; i++) cyc();
    init   = 1'b1;
    rd_req = 1'b1;
    rd_idx = 2'd1;
    cyc();
    chk("sinit_grant", grant, 0);
    chk("sinit_rd_valid", rd_valid, 0);
    init   = 1'b0;
    rd_req = 1'b0;
    cyc();
    chk("sinit_idle", idle, 1);
    cyc();
    chk("sinit_resume_ch3", grant, 4'b1000);
    req = 4'b0000;
    cyc();
    for (int i = 0; i < 4; i++) rd_chk(2'(i), (i == 3) ? 6'd1 : 6'd0);

    // Async reset between edges while channel 1 is granted.
    req = 4'b0010;
    cyc();
    chk("async_pre_grant", grant, 4'b0010);
    #2;
    reset_L = 1'b0;
    req     = 4'b0000;
    model_reset();
    #1;
    chk_zero("async");
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) rd_chk(2'(i), 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arbitro_contador.md
Name: arbitro_contador

Overview:
- Round-robin arbiter that shares one push path between 4 requesters and keeps a 6-bit push counter per requester.
- Sits in front of the shared datapath (FIFO/counter stage). It drives one registered push and push_id per cycle.
- Offers a one-cycle-latency read port so the checker or probador can sample any channel's count.

Parameters:
N_REQ, 4, number of requesters (the RTL supports exactly 4; the parameter is for documentation and width derivation)
CNT_W, 6, width of each per-channel counter and of rd_cuenta
IDX_W, 2, width of push_id and rd_idx

Ports:
clk  input  1  system clock; everything is registered on the rising edge
reset_L  input  1  asynchronous reset, active low
init  input  1  synchronous soft-init; forces the INIT state
req  input  N_REQ  request per channel, level-sensitive
grant  output  N_REQ  one-hot grant, registered
push  output  1  push to the shared datapath; equals |grant
push_id  output  IDX_W  index of the granted channel
idle  output  1  high while in the IDLE state
rd_req  input  1  count read request
rd_idx  input  IDX_W  channel to read
rd_valid  output  1  read response strobe
rd_cuenta  output  CNT_W  count of the requested channel

Behaviour:
Reset and clocking
- One clock, clk. Reset is asynchronous and active-low (reset_L); the polarity and synchronicity are fixed.
- While reset_L=0, all of the following are forced to 0: grant, push, push_id, rd_valid, rd_cuenta, idle, all 4 counters, and the priority pointer. The state is INIT.

States (encoding is free)
- INIT: counters held at 0; grant=0, push=0, idle=0.
  - Next edge with init=0 goes to IDLE.
- IDLE: idle=1, grant=0.
  - Next edge with req!=0 and init=0 goes to ACTIVE and issues the first grant on that same edge.
- ACTIVE: idle=0.
  - At every edge with req!=0, grant the winner.
  - At an edge with req==0, go to IDLE with grant=0 and push=0.
- init=1 at any edge, in any state, goes to INIT on that edge. This clears the counters and grant and leaves the pointer unchanged.
- init has priority over req and rd_req.

Arbitration
- Pointer ptr (IDX_W bits), reset value 0. It is the highest-priority channel.
- Winner = first asserted req scanning ptr, ptr+1, … mod 4.
- At an edge with a winner w, all of the following take effect on that edge:
  - grant <= onehot(w)
  - push <= 1
  - push_id <= w
  - cnt[w] <= cnt[w]+1
  - ptr <= (w+1) mod 4
- One grant per cycle. A channel that holds req continuously while others also request is granted at most once every 4 cycles.
- A single requester holding req is granted every cycle.
- The pointer is unchanged on cycles with no winner.

Counters
- cnt[i] wraps modulo 2^CNT_W: 63+1 goes to 0, with no flag.
- An increment is visible on rd_cuenta only for reads sampled after the incrementing edge.

Read port
- rd_req=1 sampled at edge k gives, at edge k: rd_valid <= 1 and rd_cuenta <= cnt[rd_idx] as it was before edge k. This means a read simultaneous with an increment of the same channel returns the old value.
- rd_valid is high for one cycle per sampled request; back-to-back reads give back-to-back responses.
- rd_cuenta holds its value when rd_valid=0.
- A read sampled while in INIT, or on an edge where init=1, is dropped: rd_valid <= 0.

Reset mid-operation
- reset_L falling clears all outputs immediately, without waiting for clk. This includes any grant in flight.
- After reset_L rises, the first action is INIT to IDLE at the next edge with init=0.

Test Plan:
1. Basic init:
   - Stimulus: hold reset_L=0 for 2 cycles, release, keep init=0.
   - Required: all outputs 0 during reset; idle=1 one edge after release.
2. Single requester:
   - Stimulus: req=0001 for 5 edges, then 0000.
   - Required: grant=0001 and push=1 for 5 cycles, push_id=0; then IDLE with idle=1.
   - Read of rd_idx=0 returns rd_cuenta=5 with rd_valid one cycle after rd_req.
3. Round-robin fairness:
   - Stimulus: req=1111 held for 8 edges from ptr=0.
   - Required: grants in order 0001,0010,0100,1000,0001,…; each counter reads 2.
   - Repeat with req=1010 from ptr=0: grants alternate 0010,1000.
4. Wrap-around and simultaneous read:
   - Stimulus: req=0100 for 64 edges.
   - Required: cnt[2] returns to 0.
   - A read of idx 2 on the same edge as the 64th grant returns 63; the read on the next edge returns 0.
5. Soft init mid-burst:
   - Stimulus: req=1111 active, pulse init=1 for one edge after 3 grants, with rd_req=1 on that edge.
   - Required: grant=0 and all counters 0 on that edge; rd_valid=0.
   - Arbitration then resumes from ptr=3 (channel 3 first) once back through IDLE.
6. Async reset mid-burst:
   - Stimulus: drop reset_L between clock edges while grant=0010.
   - Required: grant, push and counters go to 0 immediately, before the next clk edge.
